// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table (Q1.16), pi constants,
// vectoring FSM state encoding and the 1/K shift-add taps.
package cordic_pkg;

    // round(atan(2^-i) * 65536), i = 0..15; also feeds the rotation CORDIC atan ROM
    localparam int ATAN_TABLE [16] = '{
        51472, 30385, 16055, 8150, 4091, 2047, 1024, 512,
        256,   128,   64,    32,   16,   8,    4,    2
    };

    localparam int PI   = 205887;   // pi   in Q3.16
    localparam int PI_2 = 102944;   // pi/2 in Q3.16

    // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
    localparam int INV_K_POS_SHIFT [2] = '{1, 3};
    localparam int INV_K_NEG_SHIFT [3] = '{6, 9, 13};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

endpackage

// File: rtl/cordic_vec_fsm.sv
// Control for the vectoring CORDIC: state register, iteration counter,
// busy/done generation and datapath enables.
// CORDIC_GAIN_COMP_EN inserts the SCALE state between ITER and DONE.
module cordic_vec_fsm
    import cordic_pkg::*;
#(
    parameter int ITER = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       load_o,
    output logic       step_o,
    output logic       scale_o,
    output logic       out_o,
    output logic [3:0] iter_o
);

    state_t     state_q, state_d;
    logic [3:0] iter_q, iter_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // State, counter and handshake registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter update and datapath enables
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        load_o  = 1'b0;
        step_o  = 1'b0;
        scale_o = 1'b0;
        out_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    iter_d  = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                step_o = 1'b1;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_SCALE: begin
                scale_o = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                out_o   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // busy/done are registered so they change on the same edge as the outputs
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign iter_o = iter_q;

endmodule

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: (x, y) -> uncompensated magnitude and atan2(y, x).
// Defining CORDIC_GAIN_COMP_EN adds a 1/K scaling step so mag_out is the
// true magnitude (one extra cycle of latency).
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int FIXED_POINT = 14,
    parameter int ITER        = 15,
    parameter int ANGLE_W     = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [FIXED_POINT-1:0]   data_in_x,
    input  logic [FIXED_POINT-1:0]   data_in_y,
    output logic                     busy,
    output logic                     done,
    output logic [FIXED_POINT+1:0]   mag_out,
    output logic [ANGLE_W-1:0]       angle_out
);

    localparam int W = FIXED_POINT + 2;
    localparam logic signed [ANGLE_W-1:0] PI_Z = ANGLE_W'(PI);

    logic       load_en, step_en, scale_en, out_en;
    logic [3:0] iter;

    logic signed [W-1:0]       x_ext, y_ext, x_sh, y_sh;
    logic signed [W-1:0]       x_q, x_d, y_q, y_d, mag_q, mag_d;
    logic signed [ANGLE_W-1:0] z_q, z_d, angle_q, angle_d, atan_i;
    logic                      zero_q, zero_d;

    cordic_vec_fsm #(
        .ITER (ITER)
    ) u_fsm (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .load_o  (load_en),
        .step_o  (step_en),
        .scale_o (scale_en),
        .out_o   (out_en),
        .iter_o  (iter)
    );

    assign x_ext  = {{2{data_in_x[FIXED_POINT-1]}}, data_in_x};
    assign y_ext  = {{2{data_in_y[FIXED_POINT-1]}}, data_in_y};
    assign x_sh   = x_q >>> iter;
    assign y_sh   = y_q >>> iter;
    assign atan_i = ANGLE_W'(ATAN_TABLE[iter]);

    // Datapath registers: x/y/z iteration state and held outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            angle_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            angle_q <= angle_d;
        end
    end

    // Quadrant fold on load, micro-rotation per step, optional 1/K scale
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        angle_d = angle_q;
        if (load_en) begin
            zero_d = (x_ext == '0) && (y_ext == '0);
            if (x_ext[W-1]) begin
                x_d = -x_ext;
                y_d = -y_ext;
                z_d = y_ext[W-1] ? -PI_Z : PI_Z;
            end else begin
                x_d = x_ext;
                y_d = y_ext;
                z_d = '0;
            end
        end else if (step_en) begin
            if (!y_q[W-1]) begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
                z_d = z_q + atan_i;
            end else begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
                z_d = z_q - atan_i;
            end
            // with y pinned at zero the yr>=0 rule would walk z up the whole table
            if (zero_q) begin
                z_d = z_q;
            end
        end else if (scale_en) begin
`ifdef CORDIC_GAIN_COMP_EN
            x_d = (x_q >>> INV_K_POS_SHIFT[0]) + (x_q >>> INV_K_POS_SHIFT[1])
                - (x_q >>> INV_K_NEG_SHIFT[0]) - (x_q >>> INV_K_NEG_SHIFT[1])
                - (x_q >>> INV_K_NEG_SHIFT[2]);
`else
            x_d = x_q;
`endif
        end
        if (out_en) begin
            mag_d   = x_q;
            angle_d = z_q;
        end
    end

    assign mag_out   = mag_q;
    assign angle_out = angle_q;

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
- Vectoring-mode CORDIC: the inverse direction of the rotation datapath. Takes a Cartesian point (x, y) and returns magnitude and angle, i.e. atan2(y, x).
- The block has its own control FSM and start/busy/done handshake. It iterates one micro-rotation per clock and drives y toward 0 while accumulating the rotation angle.
- Sits beside the rotation CORDIC so phase can be recovered from rotated samples and fed back as theta_rad.

Parameters:
- FIXED_POINT, 14, input data width, signed Q2.12.
- ITER, 15, number of micro-rotations; shift values 0..ITER-1, max 15.
- ANGLE_W, 19, angle output width, signed Q3.16, range ±pi.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, synchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- data_in_x, input, FIXED_POINT, signed x operand, Q2.12.
- data_in_y, input, FIXED_POINT, signed y operand, Q2.12.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when results are valid.
- mag_out, output, FIXED_POINT+2, unsigned-valued signed Q4.12 magnitude.
- angle_out, output, ANGLE_W, signed Q3.16 angle in radians.

Behaviour:
- Reset: synchronous, active-low, on rising clk with rst=0.
  - FSM goes to IDLE.
  - busy=0, done=0, mag_out=0, angle_out=0.
  - Internal x/y/z registers and the iteration counter clear to 0.
- FSM states: IDLE -> ITER -> (SCALE, only with the feature) -> DONE -> IDLE.
- IDLE, start=1: load operands with quadrant fold, sign-extended to W = FIXED_POINT+2 bits. Clear counter i.
  - If x<0: xr = -x, yr = -y, zr = (y>=0) ? +PI : -PI, with PI = 205887.
  - Otherwise: xr = x, yr = y, zr = 0.
  - Negating x = -2^(FIXED_POINT-1) must not overflow; the W-bit extension guarantees this.
- ITER, one step per cycle, for i = 0..ITER-1, using arithmetic right shifts (>>>):
  - If yr>=0: xr += yr>>>i; yr -= xr>>>i; zr += ATAN[i].
  - Otherwise: xr -= yr>>>i; yr += xr>>>i; zr -= ATAN[i].
  - All updates use the old register values, not partially updated ones.
  - ATAN[i] = round(atan(2^-i)*65536), sign-extended to ANGLE_W.
  - Leave ITER when i = ITER-1.
- DONE: register mag_out = xr and angle_out = zr, pulse done=1, drop busy, return to IDLE.
- Latency: start sampled at cycle 0 -> done=1 at cycle ITER+1 (16 with defaults). Throughput is one result per ITER+2 cycles.
- Output hold: mag_out and angle_out keep their values until the next DONE.
- Output ranges:
  - mag_out is uncompensated, ≈ 1.64676 * sqrt(x²+y²).
  - angle_out is in [-PI, +PI]; x<0, y=0 yields +PI.
- Boundary conditions:
  - start while busy: ignored, with no queuing.
  - start in the same cycle as done (DONE state): ignored. Accepted next cycle in IDLE.
  - x=0, y=0: mag_out=0, angle_out=0.
  - Operand changes after acceptance have no effect on the result.
  - rst=0 mid-operation: all outputs return to reset values on that edge and the result is discarded.
- Arithmetic: W-bit two's-complement adders, no saturation needed. Worst case |mag| ≈ 4.66 fits Q4.12.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - Adds a SCALE state between ITER and DONE, so latency becomes ITER+2.
  - SCALE computes xr = (xr>>>1) + (xr>>>3) - (xr>>>6) - (xr>>>9) - (xr>>>13), approximating 1/K ≈ 0.6073.
  - mag_out is then the true magnitude within ±4 LSB.
- Undefined: no SCALE state, uncompensated magnitude, latency ITER+1.

Decomposition:
- Package cordic_pkg holds:
  - the ATAN_TABLE constant array (16 entries, Q1.16), shared with the rotation CORDIC's atan ROM;
  - the PI constant (205887) and PI_2 constant (102944);
  - the FSM state enum (IDLE, ITER, SCALE, DONE);
  - INV_K shift taps.
- One sub-module, cordic_vec_fsm: state register, iteration counter, busy/done generation, and load/step/scale enables.
- Datapath x/y/z registers and add/sub live in the top.

Test Plan:
- Expected values assume the feature is undefined unless noted. Angle tolerance ±8 LSB, magnitude tolerance ±6 LSB.
- x=4096, y=0, start -> done at cycle 16; mag_out≈6745, angle_out≈0.
- x=0, y=4096 -> angle_out≈102944 (pi/2), mag_out≈6745.
- x=-4096, y=0 -> angle_out≈+205887. x=-4096, y=-1 -> angle_out≈-205887 region (negative, near -PI).
- x=4096, y=4096 -> angle_out≈51472, mag_out≈9539. With CORDIC_GAIN_COMP_EN: mag_out≈5793 and done at cycle 17.
- start pulsed again at cycles 3 and 16 -> both ignored, exactly one done pulse. rst=0 at cycle 8 -> busy=0, outputs 0 next edge, no done.
- x=-8192, y=0 and x=0, y=0 -> no overflow; mag≈13490 with angle≈+PI, and mag=0 with angle=0 respectively.
